// File: rtl/rt_preload_ctrl_if.sv
// rtl/rt_preload_ctrl_if.sv - racetrack LiM data memory port B bundle
interface rt_preload_ctrl_if #(
    parameter int ADDR_WIDTH  = 22,
    parameter int FUNCT_WIDTH = 3
);
    logic                   mem_en;
    logic                   mem_we;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic [31:0]            mem_wdata;
    logic [3:0]             mem_be;
    logic [FUNCT_WIDTH-1:0] mem_funct;
    logic                   mem_we_funct;
    logic [ADDR_WIDTH-1:0]  mem_range;
    logic                   mem_rvalid;
    logic [31:0]            mem_rdata;

    modport master (
        output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_funct, mem_we_funct, mem_range,
        input  mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_funct, mem_we_funct, mem_range,
        output mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/rt_preload_ctrl.sv
// rtl/rt_preload_ctrl.sv - firmware preload sequencer and permanent port-B owner for the LiM memory
// Optional read-back compare of every written word: define RT_PRELOAD_VERIFY_EN.
module rt_preload_ctrl #(
    parameter int  ADDR_WIDTH     = 22,
    parameter int  FUNCT_WIDTH    = 3,
    parameter int  NUM_WORDS      = 4153,
    parameter int  BASE_ADDR      = 0,
    parameter int  TIMEOUT_CYCLES = 256,
    localparam int CNT_W          = (NUM_WORDS > 0) ? $clog2(NUM_WORDS + 1) : 1,
    localparam int TMO_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic                   src_valid_i,
    input  logic [31:0]            src_data_i,
    output logic                   src_ready_o,
    input  logic                   core_en_i,
    input  logic                   core_we_i,
    input  logic [ADDR_WIDTH-1:0]  core_addr_i,
    input  logic [31:0]            core_wdata_i,
    input  logic [3:0]             core_be_i,
    input  logic [FUNCT_WIDTH-1:0] core_funct_i,
    input  logic                   core_we_funct_i,
    input  logic [ADDR_WIDTH-1:0]  core_range_i,
    output logic                   core_rvalid_o,
    output logic [31:0]            core_rdata_o,
    output logic                   core_stall_o,
    rt_preload_ctrl_if.master      mem,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   error_o,
    output logic                   fetch_enable_o,
    output logic [CNT_W-1:0]       words_loaded_o
);
    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_WRITE,
        S_WAIT_WR,
`ifdef RT_PRELOAD_VERIFY_EN
        S_READ,
        S_WAIT_RD,
`endif
        S_GAP,
        S_SETTLE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                  state_q, state_d;
    logic [31:0]             data_q;
    logic [CNT_W-1:0]        idx_q;
    logic [TMO_W-1:0]        tmo_q;
    logic [1:0]              settle_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    mem_en_q, mem_we_q, ready_q, busy_q, done_q, error_q, stall_q;
    logic                    accept, tmo_hit, last_word, in_wait;

    assign tmo_hit   = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign last_word = (32'(idx_q) == NUM_WORDS);

`ifdef RT_PRELOAD_VERIFY_EN
    assign in_wait = (state_q == S_WAIT_WR) || (state_q == S_WAIT_RD);
    assign accept  = (state_q == S_WAIT_RD) && mem.mem_rvalid && (mem.mem_rdata == data_q);
`else
    assign in_wait = (state_q == S_WAIT_WR);
    assign accept  = (state_q == S_WAIT_WR) && mem.mem_rvalid;
`endif

    // rvalid is checked before the timeout so a response on the final allowed cycle still counts
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start_i) state_d = (NUM_WORDS == 0) ? S_SETTLE : S_FETCH;
            S_FETCH:   if (src_valid_i && ready_q) state_d = S_WRITE;
            S_WRITE:   state_d = S_WAIT_WR;
            S_WAIT_WR: begin
                if (mem.mem_rvalid) begin
`ifdef RT_PRELOAD_VERIFY_EN
                    state_d = S_READ;
`else
                    state_d = S_GAP;
`endif
                end else if (tmo_hit) begin
                    state_d = S_ERROR;
                end
            end
`ifdef RT_PRELOAD_VERIFY_EN
            S_READ:    state_d = S_WAIT_RD;
            S_WAIT_RD: begin
                if (mem.mem_rvalid) state_d = (mem.mem_rdata == data_q) ? S_GAP : S_ERROR;
                else if (tmo_hit)   state_d = S_ERROR;
            end
`endif
            S_GAP:     state_d = last_word ? S_SETTLE : S_FETCH;
            // four cycles here place DONE at start + NUM_WORDS*(3+L) + 4
            S_SETTLE:  if (settle_q == 2'd3) state_d = S_DONE;
            default:   state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            data_q   <= '0;
            idx_q    <= '0;
            tmo_q    <= '0;
            settle_q <= '0;
            addr_q   <= '0;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            stall_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            if (ready_q && src_valid_i) data_q <= src_data_i;
            if (accept) idx_q <= idx_q + 1'b1;
            if ((state_d != state_q) || !in_wait) tmo_q <= '0;
            else                                  tmo_q <= tmo_q + 1'b1;
            settle_q <= (state_q == S_SETTLE) ? settle_q + 2'd1 : 2'd0;
            if (state_d == S_WRITE)
                addr_q <= ADDR_WIDTH'(BASE_ADDR) + (ADDR_WIDTH'(idx_q) << 2);
`ifdef RT_PRELOAD_VERIFY_EN
            mem_en_q <= (state_d == S_WRITE) || (state_d == S_READ);
`else
            mem_en_q <= (state_d == S_WRITE);
`endif
            mem_we_q <= (state_d == S_WRITE);
            ready_q  <= (state_d == S_FETCH);
            busy_q   <= !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERROR));
            done_q   <= (state_d == S_DONE);
            error_q  <= (state_d == S_ERROR);
            stall_q  <= (state_d != S_DONE);
        end
    end

    assign src_ready_o    = ready_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign fetch_enable_o = done_q;
    assign core_stall_o   = stall_q;
    assign words_loaded_o = idx_q;

    // once DONE the core owns port B outright; before that LiM controls are forced off
    assign core_rvalid_o    = done_q & mem.mem_rvalid;
    assign core_rdata_o     = done_q ? mem.mem_rdata : 32'h0;
    assign mem.mem_en       = done_q ? core_en_i    : mem_en_q;
    assign mem.mem_we       = done_q ? core_we_i    : mem_we_q;
    assign mem.mem_addr     = done_q ? core_addr_i  : addr_q;
    assign mem.mem_wdata    = done_q ? core_wdata_i : data_q;
    assign mem.mem_be       = done_q ? core_be_i    : {4{mem_we_q}};
    assign mem.mem_funct    = done_q ? core_funct_i : '0;
    assign mem.mem_we_funct = done_q & core_we_funct_i;
    assign mem.mem_range    = done_q ? core_range_i : '0;
endmodule

// File: tb/tb_rt_preload_ctrl.sv
// tb/tb_rt_preload_ctrl.sv - self-checking bench for rt_preload_ctrl
module tb_rt_preload_ctrl;
    localparam int AW  = 22;
    localparam int FW  = 3;
    localparam int NW  = 4;
    localparam int TMO = 8;
    localparam int CW  = $clog2(NW + 1);
`ifdef RT_PRELOAD_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0, start_i = 1'b0;
    logic src_valid_i = 1'b0, src_ready_o;
    logic [31:0] src_data_i = '0;
    logic core_en_i = 1'b0, core_we_i = 1'b0, core_we_funct_i = 1'b0;
    logic [AW-1:0] core_addr_i = '0, core_range_i = '0;
    logic [31:0] core_wdata_i = '0;
    logic [3:0] core_be_i = '0;
    logic [FW-1:0] core_funct_i = '0;
    logic core_rvalid_o, core_stall_o, busy_o, done_o, error_o, fetch_enable_o;
    logic [31:0] core_rdata_o;
    logic [CW-1:0] words_loaded_o;

    rt_preload_ctrl_if #(.ADDR_WIDTH(AW), .FUNCT_WIDTH(FW)) mem_if ();

    rt_preload_ctrl #(.ADDR_WIDTH(AW), .FUNCT_WIDTH(FW), .NUM_WORDS(NW),
                      .BASE_ADDR(0), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i),
        .src_valid_i(src_valid_i), .src_data_i(src_data_i), .src_ready_o(src_ready_o),
        .core_en_i(core_en_i), .core_we_i(core_we_i), .core_addr_i(core_addr_i),
        .core_wdata_i(core_wdata_i), .core_be_i(core_be_i), .core_funct_i(core_funct_i),
        .core_we_funct_i(core_we_funct_i), .core_range_i(core_range_i),
        .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o), .core_stall_o(core_stall_o),
        .mem(mem_if.master),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .fetch_enable_o(fetch_enable_o),
        .words_loaded_o(words_loaded_o)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0, leak = 0;
    int lat = 3, corrupt_idx = -1, rcnt = 0;
    bit drop = 1'b0, resp_on = 1'b1, noise = 1'b0;
    logic rsp_valid = 1'b0, man_valid = 1'b0;
    logic [31:0] rsp_data = '0, pend_data = '0, man_data = '0;
    logic [31:0] words [NW];
    logic [31:0] shadow [int];
    int src_ptr = 0, stall_at = -1, stall_left = 0;
    bit hs_pend = 1'b0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [3:0]    be;
        logic          we;
        logic [FW-1:0] funct;
        logic          wef;
        logic [AW-1:0] rng;
    } wr_t;
    wr_t wq[$];

    typedef struct {
        int lat;
        int stall_at;
        int stall_len;
        bit plan;
        int exp_delta;
    } vec_t;

    assign mem_if.mem_rvalid = resp_on ? rsp_valid : man_valid;
    assign mem_if.mem_rdata  = resp_on ? rsp_data  : man_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // memory model: answers each port-B request L cycles after the request cycle
    initial forever begin
        @(negedge clk);
        rsp_valid = 1'b0;
        if (!rst_n) begin
            rcnt = 0;
        end else begin
            if (!done_o && core_rvalid_o) leak++;
            if (rcnt > 0) begin
                rcnt--;
                if (rcnt == 0 && !drop) begin
                    rsp_valid = 1'b1;
                    rsp_data  = pend_data;
                end
            end
            if (mem_if.mem_en && !done_o) begin
                if (mem_if.mem_we) begin
                    wq.push_back('{addr: mem_if.mem_addr, data: mem_if.mem_wdata, be: mem_if.mem_be,
                                   we: mem_if.mem_we, funct: mem_if.mem_funct,
                                   wef: mem_if.mem_we_funct, rng: mem_if.mem_range});
                    shadow[int'(mem_if.mem_addr)] = mem_if.mem_wdata;
                    pend_data = 32'h0;
                end else begin
                    pend_data = shadow.exists(int'(mem_if.mem_addr)) ? shadow[int'(mem_if.mem_addr)] : 32'h0;
                    if (int'(mem_if.mem_addr >> 2) == corrupt_idx) pend_data = 32'hDEADBEEF;
                end
                rcnt = lat;
            end
        end
    end

    // image source with an optional stall before one chosen word
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            src_ptr = 0;
            hs_pend = 1'b0;
            src_valid_i = 1'b0;
        end else begin
            if (hs_pend) src_ptr++;
            if (src_ptr < NW) begin
                if (src_ptr == stall_at && stall_left > 0 && src_ready_o) begin
                    src_valid_i = 1'b0;
                    stall_left--;
                end else begin
                    src_valid_i = 1'b1;
                    src_data_i  = words[src_ptr];
                end
            end else begin
                src_valid_i = 1'b0;
            end
            hs_pend = src_valid_i && src_ready_o;
        end
    end

    initial forever begin
        @(negedge clk);
        if (noise) begin
            core_en_i       = 1'($urandom);
            core_we_i       = 1'($urandom);
            core_addr_i     = AW'($urandom);
            core_wdata_i    = $urandom;
            core_be_i       = 4'($urandom);
            core_funct_i    = FW'($urandom);
            core_we_funct_i = 1'($urandom);
            core_range_i    = AW'($urandom);
        end
    end

    task automatic prep(input int l, input int sat, input int slen, input bit plan);
        @(negedge clk);
        rst_n = 1'b0;
        lat = l; drop = 1'b0; stall_at = sat; stall_left = slen;
        wq.delete(); shadow.delete(); leak = 0; resp_on = 1'b1; noise = 1'b1;
        for (int i = 0; i < NW; i++) words[i] = plan ? 32'h11111111 * (i + 1) : $urandom;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic run_load(input string tag, input int l, input int sat, input int slen, input bit plan,
                            input bit drp, input int exp_delta, input int exp_words, input int exp_wr,
                            input bit exp_err);
        int k, t, n;
        prep(l, sat, slen, plan);
        drop = drp;
        k = cyc;
        t = 0;
        while (!done_o && !error_o && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, " finished"}, 64'(done_o | error_o), 1);
        if (exp_delta >= 0) chk({tag, " latency"}, 64'(cyc - k), 64'(exp_delta));
        chk({tag, " done/fetch"}, {done_o, fetch_enable_o}, {!exp_err, !exp_err});
        chk({tag, " error/stall/busy"}, {error_o, core_stall_o, busy_o}, {exp_err, exp_err, 1'b0});
        chk({tag, " words_loaded"}, 64'(words_loaded_o), 64'(exp_words));
        chk({tag, " core_rvalid leak"}, 64'(leak), 0);
        chk({tag, " write count"}, 64'(wq.size()), 64'(exp_wr));
        n = (wq.size() < exp_wr) ? wq.size() : exp_wr;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s w%0d addr", tag, i), 64'(wq[i].addr), 64'(AW'(4 * i)));
            chk($sformatf("%s w%0d data", tag, i), 64'(wq[i].data), 64'(words[i]));
            chk($sformatf("%s w%0d ctrl", tag, i), {wq[i].be, wq[i].we, wq[i].funct, wq[i].wef, wq[i].rng},
                {4'hF, 1'b1, {FW{1'b0}}, 1'b0, {AW{1'b0}}});
        end
    endtask

    vec_t vecs[6];
    int t, l, sat, slen;
    logic [31:0] rd;

    initial begin
        vecs[0] = '{lat: 3, stall_at: -1, stall_len: 0, plan: 1'b1, exp_delta: 28};
        vecs[1] = '{lat: 3, stall_at: 2,  stall_len: 5, plan: 1'b1, exp_delta: 33};
        vecs[2] = '{lat: 1, stall_at: -1, stall_len: 0, plan: 1'b0, exp_delta: 20};
        vecs[3] = '{lat: 8, stall_at: -1, stall_len: 0, plan: 1'b0, exp_delta: 48};
        vecs[4] = '{lat: 2, stall_at: 0,  stall_len: 3, plan: 1'b0, exp_delta: 27};
        vecs[5] = '{lat: 8, stall_at: 3,  stall_len: 7, plan: 1'b0, exp_delta: 55};

        @(negedge clk);
        chk("reset status", {busy_o, done_o, error_o, fetch_enable_o, core_stall_o, src_ready_o},
            6'b000010);
        chk("reset port B", {mem_if.mem_en, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_be}, '0);
        chk("reset words_loaded", 64'(words_loaded_o), 0);

        for (int i = 0; i < 6; i++)
            run_load($sformatf("vec%0d", i), vecs[i].lat, vecs[i].stall_at, vecs[i].stall_len,
                     vecs[i].plan, 1'b0, VER ? -1 : vecs[i].exp_delta, NW, NW, 1'b0);

        for (int i = 0; i < 6; i++) begin
            l    = $urandom_range(1, TMO);
            sat  = $urandom_range(0, NW - 1);
            slen = $urandom_range(0, 6);
            run_load($sformatf("rand%0d L%0d s%0d/%0d", i, l, sat, slen), l, sat, slen, 1'b0, 1'b0,
                     VER ? -1 : NW * (3 + l) + 4 + slen, NW, NW, 1'b0);
        end

        // no response ever: ERROR 8 cycles after the first WRITE cycle ends
        run_load("timeout", 3, -1, 0, 1'b1, 1'b1, 10, 0, 1, 1'b1);
        chk("timeout port B idle", 64'(mem_if.mem_en), 0);

`ifdef RT_PRELOAD_VERIFY_EN
        corrupt_idx = 1;
        run_load("verify corrupt", 2, -1, 0, 1'b1, 1'b0, -1, 1, 2, 1'b1);
        corrupt_idx = -1;
`endif

        // reset pulse while word 2 is waiting for its write response
        prep(5, -1, 0, 1'b1);
        t = 0;
        while (wq.size() < 3 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("midreset reached word2", 64'(wq.size() >= 3), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset status", {busy_o, done_o, error_o, fetch_enable_o, core_stall_o, src_ready_o},
            6'b000010);
        chk("midreset port B", {mem_if.mem_en, mem_if.mem_addr, mem_if.mem_wdata}, '0);
        chk("midreset words_loaded", 64'(words_loaded_o), 0);
        run_load("restart", 3, -1, 0, 1'b1, 1'b0, VER ? -1 : 28, NW, NW, 1'b0);

        // handover: core drives port B directly and sees the memory response
        @(negedge clk);
        noise = 1'b0;
        resp_on = 1'b0;
        core_en_i = 1'b1; core_we_i = 1'b1; core_addr_i = AW'(32'h40); core_wdata_i = $urandom;
        core_be_i = 4'h5; core_funct_i = FW'(2); core_we_funct_i = 1'b1; core_range_i = AW'(32'h123);
        #1;
        chk("pass en/we/be", {mem_if.mem_en, mem_if.mem_we, mem_if.mem_be}, {1'b1, 1'b1, 4'h5});
        chk("pass addr", 64'(mem_if.mem_addr), 64'h40);
        chk("pass wdata", 64'(mem_if.mem_wdata), 64'(core_wdata_i));
        chk("pass lim", {mem_if.mem_funct, mem_if.mem_we_funct, mem_if.mem_range},
            {FW'(2), 1'b1, AW'(32'h123)});
        rd = $urandom;
        man_valid = 1'b1; man_data = rd;
        #1;
        chk("pass rvalid/rdata", {core_rvalid_o, core_rdata_o}, {1'b1, rd});
        man_valid = 1'b0;
        #1;
        chk("pass rvalid low", 64'(core_rvalid_o), 0);
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        core_en_i = 1'b0;
        repeat (5) @(negedge clk);
        chk("restart ignored", {done_o, fetch_enable_o, busy_o, core_stall_o, src_ready_o, mem_if.mem_en},
            6'b110000);
        chk("restart ignored words", 64'(words_loaded_o), 64'(NW));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
